// File: rtl/idft_job_sequencer.sv
// Wishbone B3 master that runs one IDFT job: load DIN, start, poll STAT, unload DOUT.
// Define IDFT_SEQ_TIMEOUT_EN to abort after POLL_TIMEOUT unsuccessful STAT reads.
module idft_job_sequencer #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    LEN_WIDTH    = 8,
  parameter int                    MAX_POINTS   = 64,
  parameter logic [ADDR_WIDTH-1:0] IDFT_BASE    = 32'h7000_0000,
  parameter int                    POLL_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_sys,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [ADDR_WIDTH-1:0]   job_src,
  input  logic [ADDR_WIDTH-1:0]   job_dst,
  input  logic [LEN_WIDTH-1:0]    job_len,
  output logic                    busy,
  output logic                    done_valid,
  output logic                    done_err,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [2:0]              wbm_cti_o,
  output logic [1:0]              wbm_bte_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_RD, S_LD_WR, S_START, S_POLL, S_ST_RD, S_ST_WR, S_DONE
  } state_t;

  state_t                state_q;
  logic                  gap_q, cyc_q, we_q, err_q;
  logic                  done_valid_q, done_err_q, job_ready_q;
  logic [ADDR_WIDTH-1:0] adr_q, src_q, dst_q;
  logic [DATA_WIDTH-1:0] dat_q, word_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH:0]    i_q;

  logic [LEN_WIDTH:0]    i_d;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] ofs, acc_adr_d;
  logic [DATA_WIDTH-1:0] acc_dat_d;
  logic                  acc_we_d;
  logic                  poll_expired;

  // Access descriptor for the current state; loaded onto the bus when the idle gap ends
  always_comb begin
    i_d       = i_q + 1'b1;
    last_word = (i_d == {1'b0, len_q});
    ofs       = ADDR_WIDTH'({i_q, 2'b00});
    acc_we_d  = 1'b0;
    acc_dat_d = word_q;
    acc_adr_d = src_q + ofs;
    case (state_q)
      S_LD_WR: begin acc_we_d = 1'b1; acc_adr_d = IDFT_BASE; end
      S_START: begin
        acc_we_d  = 1'b1;
        acc_adr_d = IDFT_BASE + ADDR_WIDTH'(4);
        acc_dat_d = DATA_WIDTH'(1);
      end
      S_POLL:  acc_adr_d = IDFT_BASE + ADDR_WIDTH'(8);
      S_ST_RD: acc_adr_d = IDFT_BASE + ADDR_WIDTH'(12);
      S_ST_WR: begin acc_we_d = 1'b1; acc_adr_d = dst_q + ofs; end
      default: ;
    endcase
  end

`ifdef IDFT_SEQ_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);
  logic [PCW-1:0] poll_cnt_q;

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys)
      poll_cnt_q <= '0;
    else if (state_q == S_START)
      poll_cnt_q <= '0;
    else if (state_q == S_POLL && !gap_q && cyc_q && !wbm_err_i && wbm_ack_i)
      poll_cnt_q <= poll_cnt_q + 1'b1;
  end

  assign poll_expired = ((poll_cnt_q + 1'b1) == PCW'(POLL_TIMEOUT));
`else
  assign poll_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      state_q      <= S_IDLE;
      gap_q        <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      job_ready_q  <= 1'b1;
      adr_q        <= '0;
      dat_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      word_q       <= '0;
      len_q        <= '0;
      i_q          <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (done_valid_q) begin
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            job_ready_q  <= 1'b1;
          end else if (job_valid && job_ready_q) begin
            job_ready_q <= 1'b0;
            src_q       <= job_src;
            dst_q       <= job_dst;
            len_q       <= job_len;
            i_q         <= '0;
            err_q       <= 1'b0;
            if (job_len == '0) begin
              state_q <= S_DONE;
            end else if (int'(job_len) > MAX_POINTS) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_LD_RD;
              cyc_q   <= 1'b1;
              we_q    <= 1'b0;
              adr_q   <= job_src;
            end
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          done_valid_q <= 1'b1;
          done_err_q   <= err_q;
        end
        default: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            cyc_q <= 1'b1;
            adr_q <= acc_adr_d;
            dat_q <= acc_dat_d;
            we_q  <= acc_we_d;
          end else if (wbm_err_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (wbm_ack_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            gap_q <= 1'b1;
            case (state_q)
              S_LD_RD: begin word_q <= wbm_dat_i; state_q <= S_LD_WR; end
              S_LD_WR: begin i_q <= i_d; state_q <= last_word ? S_START : S_LD_RD; end
              S_START: state_q <= S_POLL;
              S_POLL: begin
                if (wbm_dat_i[0]) begin
                  i_q     <= '0;
                  state_q <= S_ST_RD;
                end else if (poll_expired) begin
                  err_q   <= 1'b1;
                  gap_q   <= 1'b0;
                  state_q <= S_DONE;
                end
              end
              S_ST_RD: begin word_q <= wbm_dat_i; state_q <= S_ST_WR; end
              S_ST_WR: begin
                i_q <= i_d;
                if (last_word) begin
                  gap_q   <= 1'b0;
                  state_q <= S_DONE;
                end else begin
                  state_q <= S_ST_RD;
                end
              end
              default: ;
            endcase
          end else if (wbm_rty_i) begin
            // same state and index, so the gap reloads an identical access
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            gap_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign job_ready  = job_ready_q;
  assign busy       = (state_q != S_IDLE);
  assign done_valid = done_valid_q;
  assign done_err   = done_err_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_sel_o  = '1;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = we_q;
  assign wbm_cti_o  = 3'b000;
  assign wbm_bte_o  = 2'b00;

endmodule

// File: tb/tb_idft_job_sequencer.sv
// Randomized bench: a Wishbone slave/IDFT model plus an expected-access queue built from the job rules.
module tb_idft_job_sequencer;
  localparam int          PT   = 8;
  localparam int          MAXP = 64;
  localparam logic [31:0] BASE = 32'h7000_0000;

  logic        clk = 1'b0, rst_sys = 1'b1;
  logic        job_valid = 1'b0, job_ready, busy, done_valid, done_err;
  logic [31:0] job_src = '0, job_dst = '0;
  logic [7:0]  job_len = '0;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;

  always #5 clk = ~clk;

  idft_job_sequencer #(.MAX_POINTS(MAXP), .POLL_TIMEOUT(PT)) dut (
    .clk(clk), .rst_sys(rst_sys), .job_valid(job_valid), .job_ready(job_ready),
    .job_src(job_src), .job_dst(job_dst), .job_len(job_len), .busy(busy),
    .done_valid(done_valid), .done_err(done_err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i));

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed { logic we; logic [31:0] adr; logic [31:0] dat; } acc_t;
  acc_t expq[$];

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  function automatic logic [31:0] xform(input logic [31:0] d, input int k);
    return ~d + 32'(k);
  endfunction

  // Expected access list: load pairs, start, polls, store pairs; cut after an erroring access
  task automatic build(input logic [31:0] src, dst, input int len, npoll, err_idx, input bit store);
    expq.delete();
    if (len == 0 || len > MAXP) return;
    for (int k = 0; k < len; k++) begin
      expq.push_back({1'b0, src + 32'(4 * k), 32'h0});
      expq.push_back({1'b1, BASE, memval(src + 32'(4 * k))});
    end
    expq.push_back({1'b1, BASE + 32'h4, 32'h1});
    for (int p = 0; p < npoll; p++) expq.push_back({1'b0, BASE + 32'h8, 32'h0});
    if (store)
      for (int k = 0; k < len; k++) begin
        expq.push_back({1'b0, BASE + 32'hC, 32'h0});
        expq.push_back({1'b1, dst + 32'(4 * k), xform(memval(src + 32'(4 * k)), k)});
      end
    if (err_idx >= 0)
      while (expq.size() > err_idx + 1) void'(expq.pop_back());
  endtask

  // Slave state
  logic [31:0] din_q[$], res_q[$], log_adr[$], log_dat[$];
  logic        log_we[$];
  int  stat_reads = 0, polls_needed = 1, rty_at = -1, err_at = -1, hold_at = -1, acc_idx = 0;
  bit  stuck = 0, rty_used = 0;
  bit  in_acc = 0, gap_due = 0, nxt_due = 0, want_next = 0;
  int  wait_n = 0;
  logic [31:0] c_adr, c_dat, rnd;
  logic        c_we;

  // Slave + per-cycle bus compare
  always @(negedge clk) begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    if (rst_sys) begin
      in_acc = 0; gap_due = 0; nxt_due = 0;
    end else begin
      if (gap_due) begin
        chk("gap_idle", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        gap_due = 0; nxt_due = want_next;
      end else if (nxt_due) begin
        chk("next_issued", wbm_cyc_o, 1'b1);
        nxt_due = 0;
      end
      if (wbm_cyc_o || wbm_stb_o) begin
        chk("cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b11);
        chk("classic", {wbm_cti_o, wbm_bte_o, wbm_sel_o}, {3'b000, 2'b00, 4'hF});
        chk("busy_bus", busy, 1'b1);
        if (!in_acc) begin
          in_acc = 1; c_adr = wbm_adr_o; c_we = wbm_we_o; c_dat = wbm_dat_o;
          wait_n = (acc_idx == hold_at) ? 1000000 : $urandom_range(0, 2);
          log_adr.push_back(c_adr); log_we.push_back(c_we); log_dat.push_back(c_dat);
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_access: got %0h we=%0b expected none", c_adr, c_we);
          end else begin
            chk("acc_adr", c_adr, expq[0].adr);
            chk("acc_we", c_we, expq[0].we);
            if (expq[0].we) chk("acc_dat", c_dat, expq[0].dat);
          end
        end else begin
          chk("hold_stable", {wbm_adr_o, wbm_we_o, wbm_dat_o}, {c_adr, c_we, c_dat});
        end
        if (wait_n > 0) wait_n--;
        else begin
          in_acc = 0; gap_due = 1; rnd = $urandom; wbm_dat_i = rnd;
          if (acc_idx == err_at) begin
            wbm_err_i = 1'b1; want_next = 0; acc_idx++;
            if (expq.size() > 0) void'(expq.pop_front());
          end else if (acc_idx == rty_at && !rty_used) begin
            wbm_rty_i = 1'b1; rty_used = 1; want_next = 1;
          end else begin
            wbm_ack_i = 1'b1;
            if (c_we) begin
              if (c_adr == BASE) din_q.push_back(c_dat);
              else if (c_adr == BASE + 32'h4) begin
                res_q.delete();
                foreach (din_q[k]) res_q.push_back(xform(din_q[k], k));
                din_q.delete();
              end
            end else if (c_adr == BASE + 32'h8) begin
              stat_reads++;
              wbm_dat_i = {rnd[31:1], (!stuck && stat_reads >= polls_needed)};
            end else if (c_adr == BASE + 32'hC) begin
              wbm_dat_i = (res_q.size() > 0) ? res_q.pop_front() : 32'hDEAD_BEEF;
            end else begin
              wbm_dat_i = memval(c_adr);
            end
            if (expq.size() > 0) void'(expq.pop_front());
            acc_idx++;
            want_next = (expq.size() > 0);
          end
        end
      end else if (in_acc) begin
        checks++; errors++;
        $display("FAIL dropped_cyc: got cyc=0 expected cyc=1 at %0h", c_adr);
        in_acc = 0;
      end
    end
  end

  task automatic setup(input logic [31:0] src, dst, input int len, npoll, rty_idx, err_idx,
                       input bit stk, input bit store);
    polls_needed = npoll; stuck = stk; rty_at = rty_idx; err_at = err_idx;
    rty_used = 0; acc_idx = 0; stat_reads = 0;
    din_q.delete(); res_q.delete(); log_adr.delete(); log_we.delete(); log_dat.delete();
    build(src, dst, len, npoll, err_idx, store);
    @(negedge clk);
    chk("ready_idle", {job_ready, busy}, 2'b10);
    job_valid = 1'b1; job_src = src; job_dst = dst; job_len = 8'(len);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst_sys = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 rst_sys = 1'b0;
    expq.delete(); hold_at = -1; stuck = 0;
  endtask

  task automatic run_job(input logic [31:0] src, dst, input int len, npoll, rty_idx, err_idx,
                         input bit stk, input bit store, input bit exp_err, output int lat);
    setup(src, dst, len, npoll, rty_idx, err_idx, stk, store);
    lat = 1;
    while (!done_valid && lat < 4000) begin
      chk("busy_run", {busy, job_ready}, 2'b10);
      job_valid = 1'($urandom); job_src = $urandom; job_dst = $urandom; job_len = 8'($urandom);
      @(negedge clk); lat++;
    end
    job_valid = 1'b0;
    if (!done_valid) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_valid expected one within %0d cycles", lat);
      pulse_reset();
    end else begin
      chk("done_err", done_err, exp_err);
      chk("exp_drained", expq.size(), 0);
      chk("ready_at_done", job_ready, 1'b0);
      @(negedge clk);
      chk("done_1cyc", {done_valid, job_ready, busy}, 3'b010);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat, len, np, ri, ei, cnt;
    logic [31:0] s, d;
    bit saw_done;
    @(negedge clk);
    chk("rst_out", {job_ready, busy, done_valid, done_err, wbm_cyc_o, wbm_stb_o, wbm_we_o},
        7'b1000000);
    chk("rst_bus", {wbm_adr_o, wbm_dat_o}, 64'h0);
    #1 rst_sys = 1'b0;

    // Basic job with literal access pins
    run_job(32'h100, 32'h200, 4, 3, -1, -1, 0, 1, 0, lat);
    chk("t1_count", log_adr.size(), 20);
    chk("t1_a0", {log_we[0], log_adr[0]}, {1'b0, 32'h0000_0100});
    chk("t1_a1", {log_we[1], log_adr[1]}, {1'b1, 32'h7000_0000});
    chk("t1_a6", {log_we[6], log_adr[6]}, {1'b0, 32'h0000_010C});
    chk("t1_start", {log_we[8], log_adr[8], log_dat[8]}, {1'b1, 32'h7000_0004, 32'h1});
    chk("t1_poll3", {log_we[11], log_adr[11]}, {1'b0, 32'h7000_0008});
    chk("t1_dout", {log_we[12], log_adr[12]}, {1'b0, 32'h7000_000C});
    chk("t1_st0", {log_we[13], log_adr[13]}, {1'b1, 32'h0000_0200});
    chk("t1_st3", {log_we[19], log_adr[19]}, {1'b1, 32'h0000_020C});

    // Length boundaries
    run_job(32'h100, 32'h200, 0, 1, -1, -1, 0, 1, 0, lat);
    chk("len0_lat", lat, 2);
    chk("len0_nobus", log_adr.size(), 0);
    run_job(32'h100, 32'h200, 65, 1, -1, -1, 0, 1, 1, lat);
    chk("len65_lat", lat, 2);
    chk("len65_nobus", log_adr.size(), 0);
    run_job(32'h1000, 32'h8000, 64, 2, -1, -1, 0, 1, 0, lat);
    run_job(32'hFFFF_FFF8, 32'hFFFF_FFFC, 4, 1, -1, -1, 0, 1, 0, lat);

    // Retry on 2nd DIN write, error on DOUT read of word 2
    run_job(32'h300, 32'h400, 4, 2, 3, -1, 0, 1, 0, lat);
    chk("rty_reissue", {log_adr[3], log_dat[3]}, {log_adr[4], log_dat[4]});
    run_job(32'h300, 32'h400, 4, 2, -1, 15, 0, 1, 1, lat);

    // STAT stuck at 0
`ifdef IDFT_SEQ_TIMEOUT_EN
    run_job(32'h500, 32'h600, 3, PT, -1, -1, 1, 0, 1, lat);
    chk("timeout_reads", stat_reads, PT);
`else
    setup(32'h500, 32'h600, 3, 200, -1, -1, 1, 0);
    job_valid = 1'b0;
    saw_done = 0; cnt = 0;
    while (stat_reads < 100 && cnt < 3000) begin
      if (done_valid) saw_done = 1;
      @(negedge clk); cnt++;
    end
    chk("still_polling", {saw_done, stat_reads >= 100, busy}, 3'b011);
    pulse_reset();
`endif

    // Reset while the 2nd DIN write is stalled on the bus
    hold_at = 3;
    setup(32'h700, 32'h800, 4, 1, -1, -1, 0, 1);
    job_valid = 1'b0; cnt = 0;
    while (!(in_acc && acc_idx == 3 && wbm_we_o) && cnt < 500) begin
      @(negedge clk); cnt++;
    end
    chk("stall_seen", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o}, {3'b111, BASE});
    #2 rst_sys = 1'b1;
    #1 chk("rst_async", {wbm_cyc_o, wbm_stb_o, job_ready, busy, done_valid}, 5'b00100);
    @(negedge clk); @(negedge clk);
    #1 rst_sys = 1'b0;
    expq.delete(); hold_at = -1;
    saw_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_valid) saw_done = 1;
    end
    chk("no_done_after_rst", saw_done, 1'b0);
    run_job(32'h900, 32'hA00, 5, 2, -1, -1, 0, 1, 0, lat);

    // Randomized jobs
    for (int r = 0; r < 10; r++) begin
      len = (r == 4) ? MAXP : $urandom_range(1, 10);
      np  = $urandom_range(1, 4);
      s   = $urandom; s = s & 32'h0FFF_FFFC;
      d   = $urandom; d = d & 32'h0FFF_FFFC;
      ri  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4 * len + np) : -1;
      ei  = (r % 4 == 2) ? $urandom_range(0, 4 * len + np) : -1;
      run_job(s, d, len, np, ri, ei, 0, 1, ei >= 0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
